// File: rtl/usb_dfu_reboot_ctrl.sv
// usb_dfu_reboot_ctrl: sequences the iCE40 warmboot request after a DFU detach or manifest.
// Optional host-unplug reboot is enabled by `define USB_DFU_PRESENCE_REBOOT_EN.
module usb_dfu_reboot_ctrl #(
    parameter int unsigned DETACH_DELAY     = 48000,
    parameter int unsigned PRESENCE_TIMEOUT = 144000,
    parameter logic [1:0]  BOOT_IMAGE       = 2'b01
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sof_valid,
    input  logic [10:0] frame_index,
    input  logic        dfu_detach,
    input  logic [7:0]  dfu_state,
    output logic        host_present,
    output logic        boot,
    output logic [1:0]  boot_image,
    output logic [1:0]  seq_state
);

    localparam int unsigned TW = $clog2(PRESENCE_TIMEOUT + 1);
    localparam int unsigned DW = $clog2(DETACH_DELAY + 1);
    localparam logic [TW-1:0] TMAX = TW'(PRESENCE_TIMEOUT);
    localparam logic [DW-1:0] DLOAD = DW'(DETACH_DELAY - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        BOOT  = 2'd2
    } seq_t;

    seq_t          state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] timer_q;
    logic [10:0]   last_frame_q;
    logic          seen_q;
    logic          detach_q;
    logic          detach_vld_q;
    logic          sof_accept;
    logic          detach_trig;
    logic          manifest_trig;
    logic          presence_trig;
    logic          trigger;

    // A duplicate frame number is treated as a glitch; the first SOF always counts.
    assign sof_accept    = sof_valid && (!seen_q || frame_index != last_frame_q);
    assign host_present  = seen_q && (timer_q < TMAX);
    // detach_vld_q blocks a level that was already high when reset released.
    assign detach_trig   = dfu_detach && !detach_q && detach_vld_q;
    assign manifest_trig = (dfu_state == 8'd8);
    assign trigger       = detach_trig || manifest_trig || presence_trig;

`ifdef USB_DFU_PRESENCE_REBOOT_EN
    logic host_present_q;
    logic idle_safe;

    assign idle_safe = (dfu_state == 8'd0) || (dfu_state == 8'd2) ||
                       (dfu_state == 8'd5) || (dfu_state == 8'd9) ||
                       (dfu_state == 8'd10);
    assign presence_trig = host_present_q && !host_present && idle_safe;

    // Delayed copy of host presence for unplug edge detection.
    always_ff @(posedge clk) begin
        if (reset) host_present_q <= 1'b0;
        else       host_present_q <= host_present;
    end
`else
    assign presence_trig = 1'b0;
`endif

    // Detach edge detector state.
    always_ff @(posedge clk) begin
        if (reset) begin
            detach_q     <= 1'b0;
            detach_vld_q <= 1'b0;
        end else begin
            detach_q     <= dfu_detach;
            detach_vld_q <= 1'b1;
        end
    end

    // Host presence tracking from accepted SOF tokens.
    always_ff @(posedge clk) begin
        if (reset) begin
            seen_q       <= 1'b0;
            timer_q      <= '0;
            last_frame_q <= '0;
        end else if (sof_accept) begin
            seen_q       <= 1'b1;
            timer_q      <= '0;
            last_frame_q <= frame_index;
        end else if (timer_q != TMAX) begin
            timer_q <= timer_q + 1'b1;
        end
    end

    // Sequencer state and delay counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: arm once, count down, then hold the boot request.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d = ARMED;
                    cnt_d   = DLOAD;
                end
            end
            ARMED: begin
                if (cnt_q == '0) state_d = BOOT;
                else             cnt_d   = cnt_q - 1'b1;
            end
            BOOT:    state_d = BOOT;
            default: state_d = IDLE;
        endcase
    end

    assign boot       = (state_q == BOOT);
    assign boot_image = BOOT_IMAGE;
    assign seq_state  = state_q;

endmodule

// File: tb/tb_usb_dfu_reboot_ctrl.sv
// Testbench for usb_dfu_reboot_ctrl: vector table plus multi-cycle sequences.
// Presence-reboot expectations follow USB_DFU_PRESENCE_REBOOT_EN.
module tb_usb_dfu_reboot_ctrl;

    localparam int DD = 16;
    localparam int PT = 200;

    logic        clk = 1'b0;
    logic        reset;
    logic        sof_valid;
    logic [10:0] frame_index;
    logic        dfu_detach;
    logic [7:0]  dfu_state;
    logic        host_present;
    logic        boot;
    logic [1:0]  boot_image;
    logic [1:0]  seq_state;

    int checks = 0;
    int errors = 0;

    usb_dfu_reboot_ctrl #(
        .DETACH_DELAY(DD),
        .PRESENCE_TIMEOUT(PT),
        .BOOT_IMAGE(2'b01)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sof_valid(sof_valid),
        .frame_index(frame_index),
        .dfu_detach(dfu_detach),
        .dfu_state(dfu_state),
        .host_present(host_present),
        .boot(boot),
        .boot_image(boot_image),
        .seq_state(seq_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        sof;
        logic [10:0] fi;
        logic        det;
        logic [7:0]  st;
        logic        e_hp;
        logic        e_boot;
        logic [1:0]  e_seq;
    } vec_t;

    vec_t vecs[11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset(input logic det, input logic [7:0] st);
        reset = 1'b1; sof_valid = 1'b0; frame_index = '0;
        dfu_detach = det; dfu_state = st;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic sof(input logic [10:0] fi);
        sof_valid = 1'b1; frame_index = fi;
        tick();
        sof_valid = 1'b0;
    endtask

    // Returns ticks until sel signal matches val, or -1 after bound.
    task automatic wait_for(input int sel, input logic val, input int bound,
                            output int n);
        logic s;
        n = -1;
        for (int i = 1; i <= bound; i++) begin
            tick();
            s = (sel == 0) ? boot : host_present;
            if (s === val) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int bad;

        vecs[0]  = '{1, 0, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{0, 0, 0, 0, 0, 0, 0, 0};
        vecs[2]  = '{0, 1, 5, 0, 0, 1, 0, 0};
        vecs[3]  = '{0, 1, 5, 0, 0, 1, 0, 0};
        vecs[4]  = '{0, 0, 0, 1, 0, 1, 0, 1};
        vecs[5]  = '{0, 0, 0, 1, 0, 1, 0, 1};
        vecs[6]  = '{1, 0, 0, 1, 0, 0, 0, 0};
        vecs[7]  = '{0, 0, 0, 1, 0, 0, 0, 0};
        vecs[8]  = '{0, 0, 0, 1, 0, 0, 0, 0};
        vecs[9]  = '{0, 0, 0, 1, 8, 0, 0, 1};
        vecs[10] = '{1, 0, 0, 0, 0, 0, 0, 0};

        reset = 1'b1; sof_valid = 1'b0; frame_index = '0;
        dfu_detach = 1'b0; dfu_state = '0;
        tick();

        foreach (vecs[i]) begin
            reset = vecs[i].rst; sof_valid = vecs[i].sof;
            frame_index = vecs[i].fi; dfu_detach = vecs[i].det;
            dfu_state = vecs[i].st;
            tick();
            check($sformatf("vec%0d host_present", i), host_present, vecs[i].e_hp);
            check($sformatf("vec%0d boot", i), boot, vecs[i].e_boot);
            check($sformatf("vec%0d seq_state", i), seq_state, vecs[i].e_seq);
        end
        check("boot_image", boot_image, 1);

        // Detach edge: exact delay, then sticky boot.
        do_reset(1'b0, 8'd0);
        tick();
        dfu_detach = 1'b1;
        tick();
        check("detach armed", seq_state, 1);
        wait_for(0, 1'b1, 100, n);
        check("detach delay", n, DD);
        check("boot seq_state", seq_state, 2);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (boot !== 1'b1) bad++;
        end
        check("boot sticky", bad, 0);

        // Level held through reset release does not trigger.
        do_reset(1'b1, 8'd0);
        check("reset clears boot", boot, 0);
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (boot !== 1'b0 || seq_state !== 2'd0) bad++;
        end
        check("held detach no boot", bad, 0);
        dfu_detach = 1'b0;

        // Presence from periodic SOFs, then host loss.
        do_reset(1'b0, 8'd2);
        sof(11'd1);
        check("hp after first sof", host_present, 1);
        for (int k = 2; k <= 3; k++) begin
            repeat (99) tick();
            sof(11'(k));
        end
        check("hp still present", host_present, 1);
        wait_for(1, 1'b0, 400, n);
        check("hp fall delay", n, PT);
`ifdef USB_DFU_PRESENCE_REBOOT_EN
        tick();
        check("presence armed", seq_state, 1);
        wait_for(0, 1'b1, 100, n);
        check("presence boot delay", n, DD);
`else
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (boot !== 1'b0 || seq_state !== 2'd0) bad++;
        end
        check("presence no boot", bad, 0);
`endif

        // Duplicate frame indices never refresh the timer.
        do_reset(1'b0, 8'd0);
        sof(11'd7);
        bad = 0;
        for (int i = 1; i < PT; i++) begin
            if (i % 50 == 0) sof(11'd7);
            else tick();
            if (host_present !== 1'b1) bad++;
        end
        check("dup sof hp held", bad, 0);
        tick();
        check("dup sof hp fall", host_present, 0);

        // Busy state suppresses presence trigger; manifest still arms.
        do_reset(1'b0, 8'd4);
        sof(11'd3);
        wait_for(1, 1'b0, 400, n);
        check("busy hp fall delay", n, PT);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (seq_state !== 2'd0) bad++;
        end
        check("busy no arm", bad, 0);
        dfu_state = 8'd8;
        tick();
        check("manifest armed", seq_state, 1);
        wait_for(0, 1'b1, 100, n);
        check("manifest boot delay", n, DD);

        // Reset mid-ARMED with counter at 5, then full reload.
        do_reset(1'b0, 8'd0);
        tick();
        dfu_detach = 1'b1;
        tick();
        repeat (DD - 1 - 5) tick();
        check("mid armed", seq_state, 1);
        reset = 1'b1;
        tick();
        check("reset mid seq", seq_state, 0);
        check("reset mid boot", boot, 0);
        reset = 1'b0; dfu_detach = 1'b0;
        tick();
        dfu_detach = 1'b1;
        tick();
        check("rearmed", seq_state, 1);
        wait_for(0, 1'b1, 100, n);
        check("reload delay", n, DD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/usb_dfu_reboot_ctrl.md
# usb_dfu_reboot_ctrl

Reboot sequencer sitting directly downstream of the USB DFU core: consumes its `dfu_detach`, `dfu_state`, `sof_valid` and `frame_index` outputs and decides when to hand control to the iCE40 warmboot primitive. It tracks host presence from start-of-frame tokens and delays the boot request so the host's final handshake completes first. Outputs feed `SB_WARMBOOT` (`BOOT`, `S1`, `S0`) in the top level.

## Interface
- `DETACH_DELAY`, 48000: clk cycles between trigger and `boot` assertion (1 ms at 48 MHz); must be ≥ 1.
- `PRESENCE_TIMEOUT`, 144000: clk cycles without a SOF before host is declared absent (3 ms at 48 MHz); must be ≥ 2.
- `BOOT_IMAGE`, 2'b01: warmboot image index driven on `boot_image`.

- `clk` in 1: system clock, same domain as the DFU core's `clk`.
- `reset` in 1: synchronous, active-high.
- `sof_valid` in 1: single-cycle pulse per received SOF.
- `frame_index` in 11: frame number accompanying `sof_valid`.
- `dfu_detach` in 1: detach request level from DFU core.
- `dfu_state` in 8: current DFU state code (0 appIDLE … 10 dfuERROR).
- `host_present` out 1: host is issuing SOFs.
- `boot` out 1: warmboot request, sticky until `reset`.
- `boot_image` out 2: image select, constant `BOOT_IMAGE`.
- `seq_state` out 2: FSM state (0 IDLE, 1 ARMED, 2 BOOT).

## Operation
- Edge detect: `dfu_detach` registered; trigger on 0→1 transition only. Level held high after reset does not trigger.
- Manifest trigger: `dfu_state == 8` (dfuMANIFEST_WAIT_RESET) sampled in IDLE triggers arming.
- Presence: `seen` flag set on first `sof_valid`; timer reset to 0 on `sof_valid`, else increments, saturating at `PRESENCE_TIMEOUT`. `host_present = seen && timer < PRESENCE_TIMEOUT`.
- Frame check: a SOF whose `frame_index` equals the previous accepted SOF's index is ignored (no timer reset) — guards against duplicate-token glitches. First SOF after reset is always accepted.
- FSM:
  - IDLE: on trigger → ARMED, delay counter loaded with `DETACH_DELAY-1`.
  - ARMED: counter decrements each cycle; at 0 → BOOT. Further triggers ignored; no abort path except `reset`.
  - BOOT: `boot` = 1, held; terminal.
- Busy states 3, 4, 6, 7 (download/manifest in progress) never generate a presence-loss trigger (see Configuration). Detach/manifest triggers are not blocked.
- Simultaneous detach edge and manifest state in same cycle: single arming, no double load.

## Timing
- Reset values: `host_present` 0, `boot` 0, `seq_state` 0, timer 0, `seen` 0, delay counter 0, detach register 0.
- `boot_image` is combinational constant.
- Trigger sampled at edge N → `seq_state` = ARMED at N+1 → `boot` = 1 exactly `DETACH_DELAY` cycles after entering ARMED.
- `host_present` rises the cycle after the first accepted `sof_valid`; falls the cycle the timer reaches `PRESENCE_TIMEOUT`.
- `reset` asserted in ARMED or BOOT returns to IDLE next edge; `boot` drops.
- Counter widths: `$clog2(param+1)`; no wrap (timer saturates, delay counter stops at 0).

## Configuration
- `USB_DFU_PRESENCE_REBOOT_EN` defined: falling edge of `host_present` while in IDLE and `dfu_state` ∈ {0, 2, 5, 9, 10} is an additional trigger (host unplugged → boot user image).
- Undefined: `host_present` still computed and output; it never triggers arming.

## Test plan
- Reset, one cycle `dfu_detach` 0→1 with `DETACH_DELAY`=16 → `seq_state` 1 next cycle, `boot` = 1 exactly 16 cycles later, remains 1 for 100 cycles.
- `dfu_detach` held 1 through reset release → `boot` stays 0 for 1000 cycles.
- SOF pulses every 100 cycles, frame_index incrementing, `PRESENCE_TIMEOUT`=200 → `host_present` 1 after first; stop SOFs → falls 200 cycles after last SOF; with macro and `dfu_state`=2 → `boot` after `DETACH_DELAY`; without macro → `boot` stays 0.
- Repeated SOF with identical `frame_index` only → timer not reset, `host_present` falls on schedule.
- Presence loss with `dfu_state`=4 and macro defined → no arming; then `dfu_state`=8 → arming and `boot`.
- `reset` asserted mid-ARMED (counter at 5) → IDLE, `boot` 0; new detach edge → full `DETACH_DELAY` reload.
